// File: rtl/axi_lite_periph_bridge.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// axi_lite_periph_bridge
//
// AXI4-Lite slave front-end for a memory-mapped peripheral core. Decodes a
// base/mask address window and serialises reads (AR) and writes (AW+W) onto
// a single one-cycle peripheral request strobe. Waits for the peripheral's
// done_i and returns RDATA/RRESP or BRESP. One transaction in flight at a time.
//
// Optional feature macro: AXI_BRIDGE_TIMEOUT_EN
//   defined   : WAIT-state counter; after TIMEOUT_CYC cycles without done_i the
//               request is aborted (abort_o pulse) and answered with SLVERR.
//   undefined : WAIT waits indefinitely, abort_o is tied low.
//
// Ports
//   s_axi_aclk_i, s_axi_aresetn_i   clock (rising edge), async active-low reset
//   s_axi_ar*/r*                    AXI4-Lite read address / read data channels
//   s_axi_aw*/w*/b*                 AXI4-Lite write address / data / response
//   req_valid_o, req_write_o        one-cycle request strobe, 1 = write
//   req_addr_o                      register offset (addr[REG_ADDR_W-1:0])
//   req_wdata_o, req_wstrb_o        write data and byte enables
//   done_i, err_i, rdata_i          peripheral completion, error, read data
//   abort_o                         one-cycle pulse on request timeout
//   busy_o                          high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module axi_lite_periph_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h2001_0000,
    parameter logic [31:0] ADDR_MASK   = 32'h0000_00FF,
    parameter int          DATA_W      = 32,
    parameter int          REG_ADDR_W  = 5,
    parameter int          TIMEOUT_CYC = 1024,
    parameter int          RD_PRIORITY = 0
) (
    input  logic                  s_axi_aclk_i,
    input  logic                  s_axi_aresetn_i,
    // AR channel
    input  logic [31:0]           s_axi_araddr_i,
    input  logic                  s_axi_arvalid_i,
    output logic                  s_axi_arready_o,
    // R channel
    output logic [DATA_W-1:0]     s_axi_rdata_o,
    output logic [1:0]            s_axi_rresp_o,
    output logic                  s_axi_rvalid_o,
    input  logic                  s_axi_rready_i,
    // AW channel
    input  logic [31:0]           s_axi_awaddr_i,
    input  logic                  s_axi_awvalid_i,
    output logic                  s_axi_awready_o,
    // W channel
    input  logic [DATA_W-1:0]     s_axi_wdata_i,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb_i,
    input  logic                  s_axi_wvalid_i,
    output logic                  s_axi_wready_o,
    // B channel
    output logic [1:0]            s_axi_bresp_o,
    output logic                  s_axi_bvalid_o,
    input  logic                  s_axi_bready_i,
    // Peripheral request port
    output logic                  req_valid_o,
    output logic                  req_write_o,
    output logic [REG_ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0]     req_wdata_o,
    output logic [DATA_W/8-1:0]   req_wstrb_o,
    input  logic                  done_i,
    input  logic                  err_i,
    input  logic [DATA_W-1:0]     rdata_i,
    // Status
    output logic                  abort_o,
    output logic                  busy_o
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RRESP = 3'd3;
    localparam logic [2:0] ST_BRESP = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]            state_q,    state_d;
    logic                  rr_last_q,  rr_last_d;   // 1 = last accepted was a write
    logic                  is_write_q, is_write_d;
    logic [REG_ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0]     wdata_q,    wdata_d;
    logic [STRB_W-1:0]     wstrb_q,    wstrb_d;
    logic [DATA_W-1:0]     rdata_q,    rdata_d;
    logic [1:0]            rresp_q,    rresp_d;
    logic [1:0]            bresp_q,    bresp_d;
    logic                  rvalid_q,   rvalid_d;
    logic                  bvalid_q,   bvalid_d;

`ifdef AXI_BRIDGE_TIMEOUT_EN
    localparam int              TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             abort_q,   abort_d;
`else
    // The timeout length only matters when the counter is built.
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYC;
`endif

    // ------------------------------------------------------------------------
    // Arbitration and address decode
    // ------------------------------------------------------------------------
    logic rd_pend, wr_pend;
    logic grant_rd, grant_wr;
    logic in_idle;
    logic accept_rd, accept_wr;
    logic ar_hit, aw_hit;

    // A write is only pending with both AW and W present, so the two are
    // always taken together in one accept cycle.
    assign rd_pend = s_axi_arvalid_i;
    assign wr_pend = s_axi_awvalid_i & s_axi_wvalid_i;

    // On contention: fixed read priority, or alternate against the type of
    // the most recently accepted transaction.
    assign grant_rd = rd_pend & (~wr_pend | (RD_PRIORITY != 0) | rr_last_q);
    assign grant_wr = wr_pend & ~grant_rd;

    // Readies are gated with the reset input so they drop asynchronously
    // together with the registered outputs.
    assign in_idle   = (state_q == ST_IDLE) & s_axi_aresetn_i;
    assign accept_rd = in_idle & grant_rd;
    assign accept_wr = in_idle & grant_wr;

    assign ar_hit = ((s_axi_araddr_i & ~ADDR_MASK) == BASE_ADDR);
    assign aw_hit = ((s_axi_awaddr_i & ~ADDR_MASK) == BASE_ADDR);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        bvalid_d   = bvalid_q;
`ifdef AXI_BRIDGE_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        abort_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept_rd) begin
                    rr_last_d  = 1'b0;
                    is_write_d = 1'b0;
                    addr_d     = s_axi_araddr_i[REG_ADDR_W-1:0];
                    wdata_d    = '0;
                    wstrb_d    = '0;
                    if (ar_hit) begin
                        state_d = ST_ISSUE;
                    end else begin
                        // Outside the window: answer directly, peripheral untouched.
                        state_d  = ST_RRESP;
                        rdata_d  = '0;
                        rresp_d  = RESP_DECERR;
                        rvalid_d = 1'b1;
                    end
                end else if (accept_wr) begin
                    rr_last_d  = 1'b1;
                    is_write_d = 1'b1;
                    addr_d     = s_axi_awaddr_i[REG_ADDR_W-1:0];
                    wdata_d    = s_axi_wdata_i;
                    wstrb_d    = s_axi_wstrb_i;
                    if (aw_hit) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d  = ST_BRESP;
                        bresp_d  = RESP_DECERR;
                        bvalid_d = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef AXI_BRIDGE_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            ST_WAIT: begin
                // done_i takes precedence over a timeout in the same cycle.
                if (done_i) begin
                    if (is_write_q) begin
                        state_d  = ST_BRESP;
                        bresp_d  = err_i ? RESP_SLVERR : RESP_OKAY;
                        bvalid_d = 1'b1;
                    end else begin
                        state_d  = ST_RRESP;
                        rdata_d  = rdata_i;
                        rresp_d  = err_i ? RESP_SLVERR : RESP_OKAY;
                        rvalid_d = 1'b1;
                    end
                end
`ifdef AXI_BRIDGE_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    abort_d = 1'b1;
                    if (is_write_q) begin
                        state_d  = ST_BRESP;
                        bresp_d  = RESP_SLVERR;
                        bvalid_d = 1'b1;
                    end else begin
                        state_d  = ST_RRESP;
                        rdata_d  = '0;
                        rresp_d  = RESP_SLVERR;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            ST_RRESP: begin
                if (s_axi_rready_i) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            ST_BRESP: begin
                if (s_axi_bready_i) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                rvalid_d = 1'b0;
                bvalid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
        if (!s_axi_aresetn_i) begin
            state_q    <= ST_IDLE;
            rr_last_q  <= 1'b1;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            bvalid_q   <= bvalid_d;
        end
    end

`ifdef AXI_BRIDGE_TIMEOUT_EN
    always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
        if (!s_axi_aresetn_i) begin
            tmo_cnt_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            abort_q   <= abort_d;
        end
    end

    assign abort_o = abort_q;
`else
    assign abort_o = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_axi_arready_o = accept_rd;
    assign s_axi_awready_o = accept_wr;
    assign s_axi_wready_o  = accept_wr;

    assign s_axi_rdata_o   = rdata_q;
    assign s_axi_rresp_o   = rresp_q;
    assign s_axi_rvalid_o  = rvalid_q;
    assign s_axi_bresp_o   = bresp_q;
    assign s_axi_bvalid_o  = bvalid_q;

    assign req_valid_o = (state_q == ST_ISSUE);
    assign req_write_o = is_write_q;
    assign req_addr_o  = addr_q;
    assign req_wdata_o = wdata_q;
    assign req_wstrb_o = wstrb_q;

    assign busy_o = (state_q != ST_IDLE);

endmodule
